// File: rtl/wb_port_arbiter.sv
// Writeback-port arbiter: merges pipeline WB writes and buffered multi-cycle
// unit (mul/div) results onto a single register-file write port.
module wb_port_arbiter #(
  parameter int unsigned FIFO_DEPTH   = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pipe_regwrite_in,
  input  logic [4:0]  pipe_rd_in,
  input  logic [31:0] pipe_data_in,
  input  logic        mdu_valid_in,
  input  logic [4:0]  mdu_rd_in,
  input  logic [31:0] mdu_data_in,
  output logic        mdu_ready_out,
  output logic        pipe_stall_out,
  output logic        rf_we_out,
  output logic [4:0]  rf_addr_out,
  output logic [31:0] rf_data_out,
  output logic [15:0] stall_count_out
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);
  localparam logic [3:0]    LIMIT_C  = 4'(STARVE_LIMIT);

  logic [4:0]    mem_rd_q   [FIFO_DEPTH];
  logic [4:0]    mem_rd_d   [FIFO_DEPTH];
  logic [31:0]   mem_data_q [FIFO_DEPTH];
  logic [31:0]   mem_data_d [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [3:0]    starve_q, starve_d;
  logic          stall_q, stall_d;
  logic [15:0]   stall_cnt_q, stall_cnt_d;
  logic          rf_we_q, rf_we_d;
  logic [4:0]    rf_addr_q, rf_addr_d;
  logic [31:0]   rf_data_q, rf_data_d;

  logic fifo_nonempty;
  logic pipe_req;
  logic push;
  logic pop;

  assign fifo_nonempty   = (count_q != '0);
  assign mdu_ready_out   = (count_q < DEPTH_C);
  assign pipe_req        = pipe_regwrite_in && (pipe_rd_in != '0);
  // Results targeting x0 complete the handshake but never occupy a slot.
  assign push            = mdu_valid_in && mdu_ready_out && (mdu_rd_in != '0);
  assign pipe_stall_out  = stall_q;
  assign rf_we_out       = rf_we_q;
  assign rf_addr_out     = rf_addr_q;
  assign rf_data_out     = rf_data_q;
  assign stall_count_out = stall_cnt_q;

  // Grant selection: forced drain during stall, else pipeline, else FIFO head.
  always_comb begin
    pop       = 1'b0;
    rf_we_d   = 1'b0;
    rf_addr_d = '0;
    rf_data_d = '0;
    if (stall_q && fifo_nonempty) begin
      pop       = 1'b1;
      rf_we_d   = 1'b1;
      rf_addr_d = mem_rd_q[rd_ptr_q];
      rf_data_d = mem_data_q[rd_ptr_q];
    end else if (!stall_q && pipe_req) begin
      rf_we_d   = 1'b1;
      rf_addr_d = pipe_rd_in;
      rf_data_d = pipe_data_in;
    end else if (fifo_nonempty) begin
      pop       = 1'b1;
      rf_we_d   = 1'b1;
      rf_addr_d = mem_rd_q[rd_ptr_q];
      rf_data_d = mem_data_q[rd_ptr_q];
    end
  end

  // FIFO storage, pointers and occupancy; full blocks push even on a same-cycle pop.
  always_comb begin
    mem_rd_d   = mem_rd_q;
    mem_data_d = mem_data_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (push) begin
      mem_rd_d[wr_ptr_q]   = mdu_rd_in;
      mem_data_d[wr_ptr_q] = mdu_data_in;
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
    end
    count_d = count_q + CW'(push) - CW'(pop);
  end

  // Starvation tracking: the cycle the counter would reach the limit arms a
  // one-cycle stall and the counter restarts from zero.
  always_comb begin
    stall_d     = 1'b0;
    starve_d    = starve_q;
    stall_cnt_d = stall_cnt_q;
    if (!fifo_nonempty || pop) begin
      starve_d = '0;
    end else if ((starve_q + 4'd1) == LIMIT_C) begin
      stall_d  = 1'b1;
      starve_d = '0;
    end else begin
      starve_d = starve_q + 4'd1;
    end
    if (stall_q && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_rd_q    <= '{default: '0};
      mem_data_q  <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      starve_q    <= '0;
      stall_q     <= 1'b0;
      stall_cnt_q <= '0;
      rf_we_q     <= 1'b0;
      rf_addr_q   <= '0;
      rf_data_q   <= '0;
    end else begin
      mem_rd_q    <= mem_rd_d;
      mem_data_q  <= mem_data_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      starve_q    <= starve_d;
      stall_q     <= stall_d;
      stall_cnt_q <= stall_cnt_d;
      rf_we_q     <= rf_we_d;
      rf_addr_q   <= rf_addr_d;
      rf_data_q   <= rf_data_d;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter (FIFO_DEPTH=2, STARVE_LIMIT=4).
module tb_wb_port_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        pipe_regwrite_in;
  logic [4:0]  pipe_rd_in;
  logic [31:0] pipe_data_in;
  logic        mdu_valid_in;
  logic [4:0]  mdu_rd_in;
  logic [31:0] mdu_data_in;
  logic        mdu_ready_out;
  logic        pipe_stall_out;
  logic        rf_we_out;
  logic [4:0]  rf_addr_out;
  logic [31:0] rf_data_out;
  logic [15:0] stall_count_out;

  int n_cmp = 0;
  int n_bad = 0;

  wb_port_arbiter #(.FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clock           (clock),
    .reset           (reset),
    .pipe_regwrite_in(pipe_regwrite_in),
    .pipe_rd_in      (pipe_rd_in),
    .pipe_data_in    (pipe_data_in),
    .mdu_valid_in    (mdu_valid_in),
    .mdu_rd_in       (mdu_rd_in),
    .mdu_data_in     (mdu_data_in),
    .mdu_ready_out   (mdu_ready_out),
    .pipe_stall_out  (pipe_stall_out),
    .rf_we_out       (rf_we_out),
    .rf_addr_out     (rf_addr_out),
    .rf_data_out     (rf_data_out),
    .stall_count_out (stall_count_out)
  );

  always #5 clock = ~clock;

  // Advance one rising edge; outputs are observed 1 time unit later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    pipe_regwrite_in = 1'b0;
    pipe_rd_in       = '0;
    pipe_data_in     = '0;
    mdu_valid_in     = 1'b0;
    mdu_rd_in        = '0;
    mdu_data_in      = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [37:0] rf;
    do_reset();
    rf = {rf_we_out, rf_addr_out, rf_data_out};
    n_cmp++;
    if (rf !== 38'h0) begin
      n_bad++;
      $display("FAIL reset_rf: got %h exp %h", rf, 38'h0);
    end
    n_cmp++;
    if ({pipe_stall_out, mdu_ready_out} !== 2'b01) begin
      n_bad++;
      $display("FAIL reset_stall_ready: got %b exp 01", {pipe_stall_out, mdu_ready_out});
    end
    n_cmp++;
    if (stall_count_out !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_stall_count: got %0d exp 0", stall_count_out);
    end
  endtask

  task automatic test_pipe_only();
    logic [37:0] rf;
    pipe_regwrite_in = 1'b1;
    pipe_rd_in       = 5'd5;
    pipe_data_in     = 32'hDEADBEEF;
    tick();
    rf = {rf_we_out, rf_addr_out, rf_data_out};
    n_cmp++;
    if (rf !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
      n_bad++;
      $display("FAIL pipe_rd5: got %h exp %h", rf, {1'b1, 5'd5, 32'hDEADBEEF});
    end
    pipe_rd_in = 5'd0;
    tick();
    rf = {rf_we_out, rf_addr_out, rf_data_out};
    n_cmp++;
    if (rf !== 38'h0) begin
      n_bad++;
      $display("FAIL pipe_rd0_dropped: got %h exp %h", rf, 38'h0);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_idle_drain();
    logic [37:0] rf;
    mdu_valid_in = 1'b1;
    mdu_rd_in    = 5'd7;
    mdu_data_in  = 32'h12;
    tick();
    idle_inputs();
    n_cmp++;
    if ({rf_we_out, mdu_ready_out} !== 2'b01) begin
      n_bad++;
      $display("FAIL drain_no_bypass: got we,ready=%b exp 01", {rf_we_out, mdu_ready_out});
    end
    tick();
    rf = {rf_we_out, rf_addr_out, rf_data_out};
    n_cmp++;
    if (rf !== {1'b1, 5'd7, 32'h12}) begin
      n_bad++;
      $display("FAIL drain_write: got %h exp %h", rf, {1'b1, 5'd7, 32'h12});
    end
    n_cmp++;
    if (mdu_ready_out !== 1'b1) begin
      n_bad++;
      $display("FAIL drain_ready: got %b exp 1", mdu_ready_out);
    end
    // MDU result for x0 is accepted but discarded.
    mdu_valid_in = 1'b1;
    mdu_rd_in    = 5'd0;
    mdu_data_in  = 32'h55;
    tick();
    idle_inputs();
    tick();
    rf = {rf_we_out, rf_addr_out, rf_data_out};
    n_cmp++;
    if (rf !== 38'h0) begin
      n_bad++;
      $display("FAIL mdu_rd0_discard: got %h exp %h", rf, 38'h0);
    end
  endtask

  task automatic test_back_to_back();
    logic [37:0] rf;
    mdu_valid_in = 1'b1;
    mdu_rd_in    = 5'd1;
    mdu_data_in  = 32'h11;
    tick();
    mdu_rd_in    = 5'd2;
    mdu_data_in  = 32'h22;
    tick();
    idle_inputs();
    rf = {rf_we_out, rf_addr_out, rf_data_out};
    n_cmp++;
    if (rf !== {1'b1, 5'd1, 32'h11}) begin
      n_bad++;
      $display("FAIL order_first: got %h exp %h", rf, {1'b1, 5'd1, 32'h11});
    end
    tick();
    rf = {rf_we_out, rf_addr_out, rf_data_out};
    n_cmp++;
    if (rf !== {1'b1, 5'd2, 32'h22}) begin
      n_bad++;
      $display("FAIL order_second: got %h exp %h", rf, {1'b1, 5'd2, 32'h22});
    end
    tick();
    n_cmp++;
    if (rf_we_out !== 1'b0) begin
      n_bad++;
      $display("FAIL order_empty: got we=%b exp 0", rf_we_out);
    end
  endtask

  task automatic test_full();
    logic [37:0] rf;
    do_reset();
    pipe_regwrite_in = 1'b1;
    pipe_rd_in       = 5'd9;
    pipe_data_in     = 32'hA0;
    mdu_valid_in     = 1'b1;
    mdu_rd_in        = 5'd3;
    mdu_data_in      = 32'h33;
    tick();
    n_cmp++;
    if ({rf_we_out, rf_addr_out, mdu_ready_out} !== {1'b1, 5'd9, 1'b1}) begin
      n_bad++;
      $display("FAIL full_first: got %b exp %b", {rf_we_out, rf_addr_out, mdu_ready_out}, {1'b1, 5'd9, 1'b1});
    end
    pipe_data_in = 32'hA1;
    mdu_rd_in    = 5'd4;
    mdu_data_in  = 32'h44;
    tick();
    n_cmp++;
    if (mdu_ready_out !== 1'b0) begin
      n_bad++;
      $display("FAIL full_ready_low: got %b exp 0", mdu_ready_out);
    end
    pipe_data_in = 32'hA2;
    mdu_rd_in    = 5'd6;
    mdu_data_in  = 32'h66;
    tick();
    rf = {rf_we_out, rf_addr_out, rf_data_out};
    n_cmp++;
    if ({rf, mdu_ready_out} !== {1'b1, 5'd9, 32'hA2, 1'b0}) begin
      n_bad++;
      $display("FAIL full_blocked: got %h exp %h", {rf, mdu_ready_out}, {1'b1, 5'd9, 32'hA2, 1'b0});
    end
    idle_inputs();
    tick();
    n_cmp++;
    if ({rf_we_out, rf_addr_out} !== {1'b1, 5'd3}) begin
      n_bad++;
      $display("FAIL full_drain0: got %b exp %b", {rf_we_out, rf_addr_out}, {1'b1, 5'd3});
    end
    tick();
    n_cmp++;
    if ({rf_we_out, rf_addr_out} !== {1'b1, 5'd4}) begin
      n_bad++;
      $display("FAIL full_drain1: got %b exp %b", {rf_we_out, rf_addr_out}, {1'b1, 5'd4});
    end
    tick();
    n_cmp++;
    if ({rf_we_out, mdu_ready_out} !== 2'b01) begin
      n_bad++;
      $display("FAIL full_third_dropped: got we,ready=%b exp 01", {rf_we_out, mdu_ready_out});
    end
  endtask

  task automatic test_starve();
    logic [37:0] rf;
    do_reset();
    pipe_regwrite_in = 1'b1;
    pipe_rd_in       = 5'd9;
    pipe_data_in     = 32'hB0;
    mdu_valid_in     = 1'b1;
    mdu_rd_in        = 5'd12;
    mdu_data_in      = 32'hCAFE;
    tick();
    mdu_valid_in = 1'b0;
    mdu_rd_in    = '0;
    mdu_data_in  = '0;
    // Four unserved cycles for the buffered entry; no stall yet on the first three.
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({pipe_stall_out, rf_we_out, rf_addr_out} !== {1'b0, 1'b1, 5'd9}) begin
        n_bad++;
        $display("FAIL starve_wait%0d: got %b exp %b", i, {pipe_stall_out, rf_we_out, rf_addr_out}, {1'b0, 1'b1, 5'd9});
      end
    end
    tick();
    n_cmp++;
    if ({pipe_stall_out, rf_addr_out} !== {1'b1, 5'd9}) begin
      n_bad++;
      $display("FAIL starve_stall: got %b exp %b", {pipe_stall_out, rf_addr_out}, {1'b1, 5'd9});
    end
    tick();
    rf = {rf_we_out, rf_addr_out, rf_data_out};
    n_cmp++;
    if (rf !== {1'b1, 5'd12, 32'hCAFE}) begin
      n_bad++;
      $display("FAIL starve_fifo_write: got %h exp %h", rf, {1'b1, 5'd12, 32'hCAFE});
    end
    n_cmp++;
    if ({pipe_stall_out, stall_count_out} !== {1'b0, 16'd1}) begin
      n_bad++;
      $display("FAIL starve_count: got %h exp %h", {pipe_stall_out, stall_count_out}, {1'b0, 16'd1});
    end
    tick();
    n_cmp++;
    if ({rf_we_out, rf_addr_out, stall_count_out} !== {1'b1, 5'd9, 16'd1}) begin
      n_bad++;
      $display("FAIL starve_resume: got %h exp %h", {rf_we_out, rf_addr_out, stall_count_out}, {1'b1, 5'd9, 16'd1});
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    logic [37:0] rf;
    do_reset();
    pipe_regwrite_in = 1'b1;
    pipe_rd_in       = 5'd9;
    pipe_data_in     = 32'hC0;
    mdu_valid_in     = 1'b1;
    mdu_rd_in        = 5'd20;
    mdu_data_in      = 32'h20;
    tick();
    mdu_rd_in   = 5'd21;
    mdu_data_in = 32'h21;
    tick();
    mdu_valid_in = 1'b0;
    reset        = 1'b1;
    tick();
    reset = 1'b0;
    idle_inputs();
    rf = {rf_we_out, rf_addr_out, rf_data_out};
    n_cmp++;
    if ({rf, pipe_stall_out, mdu_ready_out} !== {38'h0, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL midreset_outputs: got %h exp %h", {rf, pipe_stall_out, mdu_ready_out}, {38'h0, 1'b0, 1'b1});
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({rf_we_out, mdu_ready_out} !== 2'b01) begin
        n_bad++;
        $display("FAIL midreset_quiet%0d: got we,ready=%b exp 01", i, {rf_we_out, mdu_ready_out});
      end
    end
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    test_reset();
    test_pipe_only();
    test_idle_drain();
    test_back_to_back();
    test_full();
    test_starve();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter FIFO_DEPTH, default 2, SHALL set the number of buffered multi-cycle-unit results (legal 2..8).
REQ-002 Parameter STARVE_LIMIT, default 4, SHALL set the consecutive unserved cycles before the buffer forces a pipeline stall (legal 1..15).
REQ-003 clock  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 reset  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 pipe_regwrite_in  input  1  SHALL flag a register write request from the pipeline WB stage.
REQ-006 pipe_rd_in  input  5  SHALL give the pipeline destination register.
REQ-007 pipe_data_in  input  32  SHALL carry the pipeline writeback data (the WB mux result).
REQ-008 mdu_valid_in  input  1  SHALL flag a completed multi-cycle (mul/div) result.
REQ-009 mdu_rd_in  input  5  SHALL give the MDU destination register.
REQ-010 mdu_data_in  input  32  SHALL carry the MDU result.
REQ-011 mdu_ready_out  output  1  SHALL indicate the buffer can accept an MDU result this cycle.
REQ-012 pipe_stall_out  output  1  SHALL tell the pipeline its WB request this cycle is not consumed.
REQ-013 rf_we_out  output  1  SHALL be the register-file write enable.
REQ-014 rf_addr_out  output  5  SHALL be the register-file write address.
REQ-015 rf_data_out  output  32  SHALL be the register-file write data.
REQ-016 stall_count_out  output  16  SHALL count cycles with pipe_stall_out high, saturating at 0xFFFF.

Function
REQ-017 Pipeline request SHALL be pipe_regwrite_in=1 and pipe_rd_in!=0; rd=0 requests are dropped silently.
REQ-018 MDU handshake: result accepted when mdu_valid_in=1 and mdu_ready_out=1; accepted entries with mdu_rd_in=0 SHALL be discarded, not pushed.
REQ-019 mdu_ready_out SHALL equal (count<FIFO_DEPTH), combinational from registered count; no push when full even if a pop occurs same cycle.
REQ-020 Buffer SHALL be in-order FIFO; pointers wrap modulo FIFO_DEPTH.
REQ-021 Grant per cycle, priority order: (a) pipe_stall_out=1 -> FIFO head; (b) pipeline request -> pipeline; (c) FIFO non-empty -> FIFO head; (d) none.
REQ-022 Granted write SHALL appear on rf_we/addr/data exactly one cycle after grant (registered); rf_we_out=0 cycles hold addr/data at 0.
REQ-023 Starve counter SHALL increment each cycle FIFO is non-empty and not popped, clear on pop or when empty.
REQ-024 When starve counter equals STARVE_LIMIT at a clock edge, pipe_stall_out SHALL be 1 for exactly the next cycle; counter then clears.
REQ-025 While pipe_stall_out=1 the pipeline SHALL hold its WB inputs; arbiter ignores them that cycle.
REQ-026 Push of an empty FIFO in same cycle as no pipeline request: entry not granted until next cycle (no bypass).
REQ-027 Same-rd hazard between pipeline and FIFO entries is not resolved here; writes occur in grant order.

Reset
REQ-028 With reset=1 at an edge: FIFO count, pointers, starve counter, stall_count_out, pipe_stall_out, rf_we_out, rf_addr_out, rf_data_out SHALL all become 0; mdu_ready_out=1 afterward.
REQ-029 Inputs in a reset cycle SHALL be ignored; FIFO contents mid-operation are discarded.

Verification
REQ-030 Pipe-only: regwrite=1, rd=5, data=0xDEADBEEF -> next cycle rf_we=1, addr=5, data=0xDEADBEEF; rd=0 -> rf_we=0.
REQ-031 Idle drain: MDU push rd=7, data=0x12 with no pipe traffic -> rf write addr=7 two cycles after push, mdu_ready stays 1.
REQ-032 Full: pipe requests every cycle, 3 MDU pushes (depth 2) -> third blocked, mdu_ready=0 after 2 accepted.
REQ-033 Starvation: one FIFO entry plus continuous pipe requests, STARVE_LIMIT=4 -> pipe_stall_out=1 for one cycle after 4 unserved cycles, FIFO entry written next cycle, stall_count_out=1.
REQ-034 Order: push rd=1,2 back-to-back, pipe idle -> writes addr 1 then 2 on consecutive cycles.
REQ-035 Reset mid-operation: FIFO holding 2 entries, reset 1 cycle -> no subsequent MDU writes, all outputs 0, mdu_ready=1.
